// File: rtl/argmax_classifier_if.sv
// Request/result bundle between the layer-2 MAC side and the argmax classifier.
// The master drives a classification request; the slave returns the winner and its confidence.
interface argmax_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16
);
  logic                           start;
  logic [NUM_CLASSES*SCORE_W-1:0] scores;
  logic                           busy;
  logic                           done;
  logic                           valid;
  logic [3:0]                     digit;
  logic [SCORE_W-1:0]             max_score;
  logic [SCORE_W:0]               margin;
  logic                           low_conf;

  modport master (
    output start, scores,
    input  busy, done, valid, digit, max_score, margin, low_conf
  );

  modport slave (
    input  start, scores,
    output busy, done, valid, digit, max_score, margin, low_conf
  );
endinterface

// File: rtl/argmax_classifier.sv
// Serial argmax over a captured vector of signed class scores, one class per cycle.
// Reports the winning index, its score, the margin over the runner-up and a low-confidence flag.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int MARGIN_TH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  argmax_classifier_if.slave   bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t                     state_q, state_d;
  logic signed [SCORE_W-1:0]  score_q [NUM_CLASSES];
  logic [3:0]                 idx_q;
  logic signed [SCORE_W-1:0]  best_q, second_q;
  logic [3:0]                 bidx_q;
  logic                       valid_q;
  logic [3:0]                 digit_q;
  logic [SCORE_W-1:0]         max_q;
  logic [SCORE_W:0]           margin_q;
  logic                       low_q;

  logic                       accept;
  logic                       last;
  logic signed [SCORE_W-1:0]  cur_s;
  logic signed [SCORE_W-1:0]  best_n, second_n;
  logic [3:0]                 bidx_n;
  logic [SCORE_W:0]           margin_n;
  logic                       low_n;

  // Handshake: start is honoured only in IDLE; busy covers the scan cycles,
  // done pulses for the single DONE cycle, and valid marks held results as current.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties; an equal score only lifts second.
  always_comb begin
    cur_s    = score_q[idx_q];
    best_n   = best_q;
    second_n = second_q;
    bidx_n   = bidx_q;
    if (cur_s > best_q) begin
      second_n = best_q;
      best_n   = cur_s;
      bidx_n   = idx_q;
    end else if (cur_s > second_q) begin
      second_n = cur_s;
    end
    margin_n = {best_n[SCORE_W-1], best_n} - {second_n[SCORE_W-1], second_n};
    low_n    = margin_n < (SCORE_W+1)'(MARGIN_TH);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
      idx_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      bidx_q   <= '0;
      valid_q  <= 1'b0;
      digit_q  <= '0;
      max_q    <= '0;
      margin_q <= '0;
      low_q    <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= bus.scores[i*SCORE_W +: SCORE_W];
      best_q   <= bus.scores[SCORE_W-1:0];
      second_q <= {1'b1, {(SCORE_W-1){1'b0}}};
      bidx_q   <= '0;
      idx_q    <= 4'd1;
      valid_q  <= 1'b0;
    end else if (state_q == SCAN) begin
      best_q   <= best_n;
      second_q <= second_n;
      bidx_q   <= bidx_n;
      idx_q    <= idx_q + 4'd1;
      if (last) begin
        digit_q  <= bidx_n;
        max_q    <= best_n;
        margin_q <= margin_n;
        low_q    <= low_n;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.valid     = valid_q;
  assign bus.digit     = digit_q;
  assign bus.max_score = max_q;
  assign bus.margin    = margin_q;
  assign bus.low_conf  = low_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: hand-computed vectors, an expected-result queue
// and a single comparison task feeding the summary counters.
module tb_argmax_classifier;

  localparam int NC = 10;
  localparam int SW = 16;

  typedef int vec_t [NC];

  logic       clk;
  logic       rst_b;
  logic [1:0] state_dbg;

  argmax_classifier_if #(.NUM_CLASSES(NC), .SCORE_W(SW)) ifc ();

  argmax_classifier #(.NUM_CLASSES(NC), .SCORE_W(SW), .MARGIN_TH(16)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (ifc.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // expected result word: {digit[3:0], max_score[15:0], margin[16:0], low_conf}
  logic [37:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*SW-1:0] pack(input vec_t v);
    logic [NC*SW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*SW +: SW] = 16'(v[i]);
    return r;
  endfunction

  task automatic check_results(input string tag);
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_expq_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_digit"},  32'(ifc.digit),     32'(e[37:34]));
    check_eq({tag, "_max"},    32'(ifc.max_score), 32'(e[33:18]));
    check_eq({tag, "_margin"}, 32'(ifc.margin),    32'(e[17:1]));
    check_eq({tag, "_low"},    32'(ifc.low_conf),  32'(e[0]));
    check_eq({tag, "_valid"},  32'(ifc.valid),     32'd1);
  endtask

  // Full classification: start pulse, bounded wait for done, latency/busy/pulse checks.
  task automatic classify(input string tag, input vec_t v, input logic [3:0] d,
                          input logic [15:0] mx, input logic [16:0] mg, input logic lc);
    int lat;
    int busy_cnt;
    bit seen;
    exp_q.push_back({d, mx, mg, lc});
    ifc.scores = pack(v);
    ifc.start  = 1'b1;
    step();
    ifc.start  = 1'b0;
    check_eq({tag, "_valid_clr"}, 32'(ifc.valid), 32'd0);
    busy_cnt = ifc.busy ? 1 : 0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ifc.done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (ifc.busy) busy_cnt++;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"},   32'(lat),  32'd9);
    check_eq({tag, "_busy_cyc"},  32'(busy_cnt), 32'd9);
    check_eq({tag, "_busy_done"}, 32'(ifc.busy), 32'd0);
    check_results(tag);
    step();
    check_eq({tag, "_done_pulse"}, 32'(ifc.done), 32'd0);
    check_eq({tag, "_idle"},       32'(state_dbg), 32'd0);
  endtask

  initial begin
    vec_t v;
    vec_t vb;
    int   dones;
    int   busy_after;

    rst_b      = 1'b0;
    ifc.start  = 1'b0;
    ifc.scores = '0;
    repeat (2) step();
    check_eq("rst_busy",   32'(ifc.busy),      32'd0);
    check_eq("rst_done",   32'(ifc.done),      32'd0);
    check_eq("rst_valid",  32'(ifc.valid),     32'd0);
    check_eq("rst_digit",  32'(ifc.digit),     32'd0);
    check_eq("rst_max",    32'(ifc.max_score), 32'd0);
    check_eq("rst_margin", 32'(ifc.margin),    32'd0);
    check_eq("rst_low",    32'(ifc.low_conf),  32'd0);
    rst_b = 1'b1;
    step();

    // 1: clear winner at class 7, runner-up 80
    v = '{0, 10, 20, 30, 40, 50, 60, 900, 70, 80};
    classify("t1", v, 4'd7, 16'd900, 17'd820, 1'b0);

    // 2: all equal negative -> index 0, zero margin
    v = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
    classify("t2", v, 4'd0, 16'hFFFB, 17'd0, 1'b1);

    // 3: full-range margin
    v = '{-32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768, -32768, -32768};
    classify("t3", v, 4'd3, 16'h7FFF, 17'd65535, 1'b0);

    // 4: ties resolve to lowest index; then a narrow win
    v = '{0, 0, 100, 0, 0, 0, 100, 0, 0, 0};
    classify("t4a", v, 4'd2, 16'd100, 17'd0, 1'b1);
    v = '{0, 0, 100, 0, 0, 0, 110, 0, 0, 0};
    classify("t4b", v, 4'd6, 16'd110, 17'd10, 1'b1);

    // 5: scores change and start re-pulses mid-scan; start during DONE
    v  = '{0, 10, 20, 30, 40, 50, 60, 900, 70, 80};
    vb = '{5000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back({4'd7, 16'd900, 17'd820, 1'b0});
    ifc.scores = pack(v);
    ifc.start  = 1'b1;
    step();                       // E0
    ifc.start  = 1'b0;
    ifc.scores = pack(vb);
    repeat (3) step();            // E1..E3
    ifc.start = 1'b1;
    step();                       // E4
    ifc.start = 1'b0;
    dones = 0;
    busy_after = 0;
    for (int k = 5; k <= 25; k++) begin
      step();
      ifc.start = 1'b0;
      if (ifc.done) begin
        dones++;
        if (dones == 1) begin
          check_eq("t5_latency", 32'(k), 32'd9);
          check_results("t5");
          ifc.start = 1'b1;       // lands on the DONE->IDLE edge
        end
      end else if (dones > 0 && ifc.busy) begin
        busy_after++;
      end
    end
    check_eq("t5_done_count", 32'(dones),      32'd1);
    check_eq("t5_busy_after", 32'(busy_after), 32'd0);
    check_eq("t5_valid_held", 32'(ifc.valid),  32'd1);
    check_eq("t5_digit_held", 32'(ifc.digit),  32'd7);

    // 6: reset at E5 aborts the scan
    v = '{0, 10, 20, 30, 40, 50, 60, 900, 70, 80};
    ifc.scores = pack(v);
    ifc.start  = 1'b1;
    step();                       // E0
    ifc.start  = 1'b0;
    repeat (4) step();            // E1..E4
    rst_b = 1'b0;
    step();                       // E5
    check_eq("t6_done",   32'(ifc.done),      32'd0);
    check_eq("t6_busy",   32'(ifc.busy),      32'd0);
    check_eq("t6_valid",  32'(ifc.valid),     32'd0);
    check_eq("t6_digit",  32'(ifc.digit),     32'd0);
    check_eq("t6_max",    32'(ifc.max_score), 32'd0);
    check_eq("t6_margin", 32'(ifc.margin),    32'd0);
    check_eq("t6_low",    32'(ifc.low_conf),  32'd0);
    rst_b = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ifc.done) dones++;
    end
    check_eq("t6_no_done", 32'(dones), 32'd0);
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    classify("t6b", v, 4'd9, 16'd1, 17'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
